// File: rtl/acoustic_onset_detector.sv
// Acoustic onset detector: rectifies the sample stream, qualifies a run of
// samples at or above threshold, fires a fixed-length detect pulse, then
// holds off and waits for a hysteresis re-arm so one onset gives one pulse.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_ARMED   | idle, tracking threshold/hyst, waiting for first loud sample
// S_QUALIFY | counting consecutive loud samples toward DEBOUNCE
// S_FIRE    | detect high, counting PULSE_LEN clock cycles
// S_HOLDOFF | ignoring HOLDOFF valid samples, still tracking peak
// S_REARM   | waiting for mag + hyst < threshold before arming again
module acoustic_onset_detector #(
    parameter int WIDTH     = 16,
    parameter int DEBOUNCE  = 3,
    parameter int PULSE_LEN = 4,
    parameter int HOLDOFF   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] threshold,
    input  logic [WIDTH-1:0] hyst,
    output logic             detect,
    output logic             busy,
    output logic [WIDTH-1:0] peak,
    output logic             peak_valid,
    output logic [15:0]      event_cnt
);

    typedef enum logic [2:0] {
        S_ARMED   = 3'd0,
        S_QUALIFY = 3'd1,
        S_FIRE    = 3'd2,
        S_HOLDOFF = 3'd3,
        S_REARM   = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0]       DEB_C    = 8'(DEBOUNCE);
    localparam logic [15:0]      PULSE_LD = 16'(PULSE_LEN - 1);
    localparam logic [15:0]      HOLD_LD  = 16'(HOLDOFF - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mag_nxt;
    logic [WIDTH-1:0] mag;
    logic             mag_v;
    logic [WIDTH-1:0] thr_r;
    logic [WIDTH-1:0] hyst_r;
    logic [7:0]       qual_cnt;
    logic [15:0]      tmr;
    logic [WIDTH-1:0] peak_q;
    logic             peak_valid_q;
    logic [15:0]      event_cnt_q;

    logic             above;
    logic             below;
    logic [WIDTH:0]   rearm_sum;
    logic             rearm_ok;
    logic             tmr_zero;
    logic             qual_done;
    logic             fire_entry;
    logic             peak_load;
    logic             peak_track;

    // Rectifier; the most negative code has no positive twin, so clamp it.
    always_comb begin
        mag_nxt = sample;
        if (sample == MIN_NEG) begin
            mag_nxt = MAX_POS;
        end else if (sample[WIDTH-1]) begin
            mag_nxt = (~sample) + ONE;
        end
    end

    // Stage 1: registered magnitude and its qualifier.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mag   <= '0;
            mag_v <= 1'b0;
        end else begin
            mag   <= mag_nxt;
            mag_v <= sample_valid & enable;
        end
    end

    // Level compares; the re-arm sum carries an extra bit so it cannot wrap.
    always_comb begin
        above      = mag_v && (mag >= thr_r);
        below      = mag_v && (mag < thr_r);
        rearm_sum  = {1'b0, mag} + {1'b0, hyst_r};
        rearm_ok   = mag_v && (rearm_sum < {1'b0, thr_r});
        tmr_zero   = (tmr == 16'd0);
        qual_done  = ((qual_cnt + 8'd1) == DEB_C);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_ARMED;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the strobes the datapath needs.
    always_comb begin
        state_nxt  = state;
        peak_load  = 1'b0;
        peak_track = 1'b0;
        if (!enable) begin
            state_nxt = S_ARMED;
        end else begin
            case (state)
                S_ARMED: begin
                    if (above) begin
                        state_nxt = (DEBOUNCE == 1) ? S_FIRE : S_QUALIFY;
                        peak_load = 1'b1;
                    end
                end
                S_QUALIFY: begin
                    peak_track = mag_v;
                    if (above && qual_done) begin
                        state_nxt = S_FIRE;
                    end else if (below) begin
                        state_nxt = S_ARMED;
                    end
                end
                S_FIRE: begin
                    peak_track = mag_v;
                    if (tmr_zero) begin
                        state_nxt = S_HOLDOFF;
                    end
                end
                S_HOLDOFF: begin
                    peak_track = mag_v;
                    if (mag_v && tmr_zero) begin
                        state_nxt = S_REARM;
                    end
                end
                S_REARM: begin
                    if (rearm_ok) begin
                        state_nxt = S_ARMED;
                    end
                end
                default: state_nxt = S_ARMED;
            endcase
        end
        fire_entry = (state_nxt == S_FIRE) && (state != S_FIRE);
    end

    // Counters, thresholds, peak tracking and event statistics.
    always_ff @(posedge clk) begin
        if (!rst) begin
            thr_r        <= '0;
            hyst_r       <= '0;
            qual_cnt     <= 8'd0;
            tmr          <= 16'd0;
            peak_q       <= '0;
            peak_valid_q <= 1'b0;
            event_cnt_q  <= 16'd0;
        end else begin
            peak_valid_q <= 1'b0;
            if (state == S_ARMED) begin
                thr_r  <= threshold;
                hyst_r <= hyst;
            end
            if (!enable) begin
                qual_cnt <= 8'd0;
                tmr      <= 16'd0;
            end else begin
                case (state)
                    S_ARMED: begin
                        if (above) begin
                            qual_cnt <= 8'd1;
                        end
                    end
                    S_QUALIFY: begin
                        if (above) begin
                            qual_cnt <= qual_cnt + 8'd1;
                        end else if (below) begin
                            qual_cnt <= 8'd0;
                        end
                    end
                    S_FIRE: begin
                        tmr <= tmr_zero ? HOLD_LD : tmr - 16'd1;
                    end
                    S_HOLDOFF: begin
                        if (mag_v) begin
                            if (tmr_zero) begin
                                peak_valid_q <= 1'b1;
                            end else begin
                                tmr <= tmr - 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
                if (fire_entry) begin
                    qual_cnt <= 8'd0;
                    tmr      <= PULSE_LD;
                    if (event_cnt_q != 16'hFFFF) begin
                        event_cnt_q <= event_cnt_q + 16'd1;
                    end
                end
                if (peak_load) begin
                    peak_q <= mag;
                end else if (peak_track && (mag > peak_q)) begin
                    peak_q <= mag;
                end
            end
        end
    end

    assign detect     = (state == S_FIRE);
    assign busy       = (state != S_ARMED);
    assign peak       = peak_q;
    assign peak_valid = peak_valid_q;
    assign event_cnt  = event_cnt_q;

endmodule

// File: tb/tb_acoustic_onset_detector.sv
// Bench for acoustic_onset_detector: directed scenarios plus a randomized run,
// all checked cycle by cycle against an event-level reference model.
module tb_acoustic_onset_detector;

    localparam int DEB = 3;
    localparam int PL  = 4;
    localparam int HO  = 8;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        sample_valid;
    logic [15:0] sample;
    logic [15:0] threshold;
    logic [15:0] hyst;
    logic        detect;
    logic        busy;
    logic [15:0] peak;
    logic        peak_valid;
    logic [15:0] event_cnt;

    int vectors;
    int miscompares;

    acoustic_onset_detector #(
        .WIDTH(16), .DEBOUNCE(DEB), .PULSE_LEN(PL), .HOLDOFF(HO)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
        .sample(sample), .threshold(threshold), .hyst(hyst),
        .detect(detect), .busy(busy), .peak(peak), .peak_valid(peak_valid),
        .event_cnt(event_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 counting a loud run, 2 pulsing,
    // 3 ignoring holdoff samples, 4 waiting to go quiet.
    int   m_mag, m_thr, m_hyst, m_mode, m_run, m_fire, m_hold, m_peak, m_evt;
    bit   m_magv;
    logic e_det, e_busy, e_pv;
    logic [15:0] e_peak, e_evt;

    task automatic model_step(input bit r, input bit en, input bit sv,
                              input logic [15:0] smp, input int thr, input int hy);
        int  s, nm, nthr, nhy;
        bit  pv, loud;
        s  = int'($signed(smp));
        nm = (s < 0) ? -s : s;
        if (nm > 32767) nm = 32767;
        pv = 1'b0;
        if (!r) begin
            m_mag = 0; m_magv = 0; m_thr = 0; m_hyst = 0; m_mode = 0;
            m_run = 0; m_fire = 0; m_hold = 0; m_peak = 0; m_evt = 0;
        end else begin
            nthr = (m_mode == 0) ? thr : m_thr;
            nhy  = (m_mode == 0) ? hy : m_hyst;
            loud = m_magv && (m_mag >= m_thr);
            if (!en) begin
                m_mode = 0; m_run = 0; m_fire = 0; m_hold = 0;
            end else begin
                case (m_mode)
                    0: if (loud) begin m_run = 1; m_peak = m_mag; m_mode = 1; end
                    1: if (m_magv) begin
                        if (m_mag > m_peak) m_peak = m_mag;
                        if (loud) begin
                            m_run++;
                            if (m_run == DEB) begin
                                m_mode = 2; m_fire = 0;
                                if (m_evt < 65535) m_evt++;
                            end
                        end else begin
                            m_mode = 0; m_run = 0;
                        end
                    end
                    2: begin
                        if (m_magv && m_mag > m_peak) m_peak = m_mag;
                        m_fire++;
                        if (m_fire == PL) begin m_mode = 3; m_hold = 0; end
                    end
                    3: if (m_magv) begin
                        if (m_mag > m_peak) m_peak = m_mag;
                        m_hold++;
                        if (m_hold == HO) begin m_mode = 4; pv = 1'b1; end
                    end
                    default: if (m_magv && (m_mag + m_hyst < m_thr)) m_mode = 0;
                endcase
            end
            m_thr = nthr; m_hyst = nhy;
            m_mag = nm; m_magv = sv & en;
        end
        e_det  = (m_mode == 2);
        e_busy = (m_mode != 0);
        e_pv   = pv;
        e_peak = 16'(m_peak);
        e_evt  = 16'(m_evt);
    endtask

    // One clock: drive inputs, advance the model at the edge, settle.
    task automatic apply(input bit r, input bit en, input bit sv, input int smp);
        rst = r; enable = en; sample_valid = sv; sample = 16'(smp);
        @(posedge clk);
        model_step(r, en, sv, 16'(smp), int'(threshold), int'(hyst));
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            if (k < 2) apply(1'b0, 1'b1, 1'b1, 5000);
            else       apply(1'b1, 1'b1, 1'b0, 0);
            vectors++;
            if ({detect, busy, peak_valid, peak, event_cnt} !== 35'd0 ||
                {detect, busy, peak_valid, peak, event_cnt} !== {e_det, e_busy, e_pv, e_peak, e_evt}) begin
                miscompares++;
                $display("FAIL reset k=%0d got det%b busy%b pv%b peak%0d cnt%0d exp all zero",
                         k, detect, busy, peak_valid, peak, event_cnt);
            end
        end
    endtask

    task automatic test_basic_fire();
        int smp[4] = '{100, 1200, -1500, 1100};
        logic [23:0] det_seen = '0;
        logic [23:0] busy_seen = '0;
        for (int k = 0; k < 24; k++) begin
            apply(1'b1, 1'b1, 1'b1, (k < 4) ? smp[k] : 0);
            det_seen[k] = detect;
            busy_seen[k] = busy;
            vectors++;
            if ({detect, busy, peak_valid, peak, event_cnt} !== {e_det, e_busy, e_pv, e_peak, e_evt}) begin
                miscompares++;
                $display("FAIL basic_fire k=%0d got det%b busy%b pv%b peak%0d cnt%0d exp det%b busy%b pv%b peak%0d cnt%0d",
                         k, detect, busy, peak_valid, peak, event_cnt, e_det, e_busy, e_pv, e_peak, e_evt);
            end
        end
        vectors++;
        if (det_seen !== 24'h0000F0) begin
            miscompares++;
            $display("FAIL basic_fire_window got %h exp 0000f0", det_seen);
        end
        vectors++;
        if (busy_seen[2:0] !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_fire_busy_rise got %b exp 100", busy_seen[2:0]);
        end
        vectors++;
        if (event_cnt !== 16'd1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_fire_end got cnt%0d busy%b exp cnt1 busy0", event_cnt, busy);
        end
    endtask

    task automatic test_glitch();
        int g[5] = '{1200, 1200, 500, 1200, 1200};
        int v2[6] = '{1, 0, 0, 1, 0, 1};
        int c0, ndet;
        c0 = int'(event_cnt);
        ndet = 0;
        for (int k = 0; k < 12; k++) begin
            apply(1'b1, 1'b1, 1'b1, (k < 5) ? g[k] : 0);
            if (detect) ndet++;
            vectors++;
            if ({detect, busy, peak_valid, peak, event_cnt} !== {e_det, e_busy, e_pv, e_peak, e_evt}) begin
                miscompares++;
                $display("FAIL glitch k=%0d got det%b busy%b pv%b peak%0d cnt%0d exp det%b busy%b pv%b peak%0d cnt%0d",
                         k, detect, busy, peak_valid, peak, event_cnt, e_det, e_busy, e_pv, e_peak, e_evt);
            end
        end
        vectors++;
        if (ndet != 0 || int'(event_cnt) != c0) begin
            miscompares++;
            $display("FAIL glitch_reject got det_cycles%0d cnt%0d exp 0 cnt%0d", ndet, event_cnt, c0);
        end
        for (int k = 0; k < 26; k++) begin
            if (k < 6) apply(1'b1, 1'b1, v2[k][0], (v2[k] != 0) ? 1200 : 5000);
            else       apply(1'b1, 1'b1, 1'b1, 0);
            if (detect) ndet++;
            vectors++;
            if ({detect, busy, peak_valid, peak, event_cnt} !== {e_det, e_busy, e_pv, e_peak, e_evt}) begin
                miscompares++;
                $display("FAIL glitch_gaps k=%0d got det%b busy%b pv%b peak%0d cnt%0d exp det%b busy%b pv%b peak%0d cnt%0d",
                         k, detect, busy, peak_valid, peak, event_cnt, e_det, e_busy, e_pv, e_peak, e_evt);
            end
        end
        vectors++;
        if (ndet != PL || int'(event_cnt) != c0 + 1) begin
            miscompares++;
            $display("FAIL glitch_gaps_fire got det_cycles%0d cnt%0d exp %0d cnt%0d", ndet, event_cnt, PL, c0 + 1);
        end
    endtask

    task automatic test_holdoff();
        int tail_s[9] = '{850, -1, -1, 799, -1, -1, 1200, -1, -1};
        int tail_b[9] = '{-1, -1, 1, -1, -1, 0, -1, -1, 1};
        int ndet, npv, pk;
        ndet = 0; npv = 0; pk = -1;
        for (int k = 0; k < 24; k++) begin
            apply(1'b1, 1'b1, 1'b1, 2000);
            if (detect) ndet++;
            if (peak_valid) begin npv++; pk = int'(peak); end
            vectors++;
            if ({detect, busy, peak_valid, peak, event_cnt} !== {e_det, e_busy, e_pv, e_peak, e_evt}) begin
                miscompares++;
                $display("FAIL holdoff k=%0d got det%b busy%b pv%b peak%0d cnt%0d exp det%b busy%b pv%b peak%0d cnt%0d",
                         k, detect, busy, peak_valid, peak, event_cnt, e_det, e_busy, e_pv, e_peak, e_evt);
            end
        end
        vectors++;
        if (ndet != PL || npv != 1 || pk != 2000 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL holdoff_noretrig got det_cycles%0d pv%0d peak%0d busy%b exp %0d 1 2000 1",
                     ndet, npv, pk, busy, PL);
        end
        for (int k = 0; k < 9; k++) begin
            apply(1'b1, 1'b1, tail_s[k] >= 0, (tail_s[k] >= 0) ? tail_s[k] : 0);
            vectors++;
            if ({detect, busy, peak_valid, peak, event_cnt} !== {e_det, e_busy, e_pv, e_peak, e_evt}) begin
                miscompares++;
                $display("FAIL hyst k=%0d got det%b busy%b pv%b peak%0d cnt%0d exp det%b busy%b pv%b peak%0d cnt%0d",
                         k, detect, busy, peak_valid, peak, event_cnt, e_det, e_busy, e_pv, e_peak, e_evt);
            end
            if (tail_b[k] >= 0) begin
                vectors++;
                if (busy !== tail_b[k][0]) begin
                    miscompares++;
                    $display("FAIL hyst_busy k=%0d got %b exp %0d", k, busy, tail_b[k]);
                end
            end
        end
        for (int k = 0; k < 4; k++) apply(1'b1, 1'b1, 1'b1, 0);
    endtask

    task automatic test_saturation();
        int npv, pk;
        npv = 0; pk = -1;
        for (int k = 0; k < 26; k++) begin
            apply(1'b1, 1'b1, 1'b1, (k < 3) ? -32768 : 0);
            if (peak_valid) begin npv++; pk = int'(peak); end
            vectors++;
            if ({detect, busy, peak_valid, peak, event_cnt} !== {e_det, e_busy, e_pv, e_peak, e_evt}) begin
                miscompares++;
                $display("FAIL saturation k=%0d got det%b busy%b pv%b peak%0d cnt%0d exp det%b busy%b pv%b peak%0d cnt%0d",
                         k, detect, busy, peak_valid, peak, event_cnt, e_det, e_busy, e_pv, e_peak, e_evt);
            end
        end
        vectors++;
        if (npv != 1 || pk != 32767) begin
            miscompares++;
            $display("FAIL saturation_peak got pv%0d peak%0d exp 1 32767", npv, pk);
        end
    endtask

    task automatic test_enable_drop();
        int c0, k, ndet;
        bit seen;
        c0 = int'(event_cnt);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 12) begin
            apply(1'b1, 1'b1, 1'b1, (k < 3) ? 1500 : 0);
            seen = detect;
            k++;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL enable_drop_wait got no detect within 12 cycles exp detect");
        end
        apply(1'b1, 1'b0, 1'b1, 1500);
        vectors++;
        if (detect !== 1'b0 || busy !== 1'b0 || int'(event_cnt) != c0 + 1 ||
            {detect, busy, peak_valid, peak, event_cnt} !== {e_det, e_busy, e_pv, e_peak, e_evt}) begin
            miscompares++;
            $display("FAIL enable_drop got det%b busy%b cnt%0d exp det0 busy0 cnt%0d",
                     detect, busy, event_cnt, c0 + 1);
        end
        ndet = 0;
        for (int j = 0; j < 26; j++) begin
            apply(1'b1, 1'b1, 1'b1, (j >= 1 && j < 4) ? 1500 : 0);
            if (detect) ndet++;
            vectors++;
            if ({detect, busy, peak_valid, peak, event_cnt} !== {e_det, e_busy, e_pv, e_peak, e_evt}) begin
                miscompares++;
                $display("FAIL reenable j=%0d got det%b busy%b pv%b peak%0d cnt%0d exp det%b busy%b pv%b peak%0d cnt%0d",
                         j, detect, busy, peak_valid, peak, event_cnt, e_det, e_busy, e_pv, e_peak, e_evt);
            end
        end
        vectors++;
        if (ndet != PL || int'(event_cnt) != c0 + 2) begin
            miscompares++;
            $display("FAIL reenable_fire got det_cycles%0d cnt%0d exp %0d cnt%0d", ndet, event_cnt, PL, c0 + 2);
        end
    endtask

    task automatic test_random();
        int thr_set[3]  = '{1000, 300, 1500};
        int hyst_set[3] = '{200, 100, 2000};
        int smp;
        bit r, en, sv;
        for (int k = 0; k < 4000; k++) begin
            if (k % 250 == 0) begin
                threshold = 16'(thr_set[$urandom_range(0, 2)]);
                hyst      = 16'(hyst_set[$urandom_range(0, 2)]);
            end
            r  = ($urandom_range(0, 599) != 0);
            en = ($urandom_range(0, 49) != 0);
            sv = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       smp = -32768;
                1:       smp = int'($signed(16'($urandom())));
                default: smp = int'($urandom_range(0, 5000)) - 2500;
            endcase
            apply(r, en, sv, smp);
            vectors++;
            if ({detect, busy, peak_valid, peak, event_cnt} !== {e_det, e_busy, e_pv, e_peak, e_evt}) begin
                miscompares++;
                $display("FAIL random k=%0d got det%b busy%b pv%b peak%0d cnt%0d exp det%b busy%b pv%b peak%0d cnt%0d",
                         k, detect, busy, peak_valid, peak, event_cnt, e_det, e_busy, e_pv, e_peak, e_evt);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0; enable = 1'b1; sample_valid = 1'b0; sample = '0;
        threshold = 16'd1000; hyst = 16'd200;
        m_mag = 0; m_magv = 0; m_thr = 0; m_hyst = 0; m_mode = 0;
        m_run = 0; m_fire = 0; m_hold = 0; m_peak = 0; m_evt = 0;
        test_reset();
        test_basic_fire();
        test_glitch();
        test_holdoff();
        test_saturation();
        test_enable_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
